// File: rtl/dmem_align_unit_pkg.sv
// Shared access-size codes, FSM state encoding and size helper for the
// data-memory alignment unit.
package dmem_align_unit_pkg;

    typedef enum logic [1:0] {
        DMEM_EXT_BYTE  = 2'b00,
        DMEM_EXT_HALF  = 2'b01,
        DMEM_EXT_WORD  = 2'b10,
        DMEM_EXT_DWORD = 2'b11
    } dmem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5
    } dmem_state_e;

    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/dmem_align_unit_lane.sv
// Combinational lane steering: two-beat byte enables / write data for stores,
// and extraction plus sign/zero extension of merged load data.
module dmem_lane_align
    import dmem_align_unit_pkg::*;
#(
    parameter int DWIDTH = 32,
    localparam int BYTES = DWIDTH / 8,
    localparam int OW = $clog2(BYTES)
) (
    input  logic [OW-1:0]       off,
    input  logic [1:0]          size,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic [DWIDTH-1:0]   rdata_lo,
    input  logic [DWIDTH-1:0]   rdata_hi,
    input  logic                is_unsigned,
    output logic [2*BYTES-1:0]  be2,
    output logic [2*DWIDTH-1:0] wdata2,
    output logic [DWIDTH-1:0]   rdata_ext
);

    logic [BYTES-1:0]    nmask;
    logic [DWIDTH-1:0]   wmasked;
    logic [2*DWIDTH-1:0] rshift;
    logic                sign;
    int                  nbytes;

    always_comb begin
        nbytes = size_bytes(size);
        if (nbytes > BYTES) begin
            nbytes = BYTES;
        end
        nmask   = '0;
        wmasked = '0;
        for (int i = 0; i < BYTES; i++) begin
            nmask[i] = (i < nbytes);
            if (i < nbytes) begin
                wmasked[8*i +: 8] = wdata[8*i +: 8];
            end
        end

        // Shifting the zero-padded mask/data across two words yields both beats at once.
        be2    = {{BYTES{1'b0}}, nmask} << off;
        wdata2 = {{DWIDTH{1'b0}}, wmasked} << {off, 3'b000};

        rshift = {rdata_hi, rdata_lo} >> {off, 3'b000};
        case (size)
            DMEM_EXT_BYTE: sign = rshift[7];
            DMEM_EXT_HALF: sign = rshift[15];
            DMEM_EXT_WORD: sign = rshift[31];
            default:       sign = rshift[DWIDTH-1];
        endcase
        sign = sign & ~is_unsigned;

        rdata_ext = '0;
        for (int i = 0; i < BYTES; i++) begin
            rdata_ext[8*i +: 8] = nmask[i] ? rshift[8*i +: 8] : {8{sign}};
        end
    end

endmodule

// File: rtl/dmem_align_unit.sv
// MEM-stage data access unit: turns one LSU request into one or two aligned
// bus beats, merges split load returns and reports a single completion.
//
// state | meaning
// IDLE  | ready for a new request
// BEAT0 | first (low) beat on the bus, waiting for mem_ready
// WAIT0 | load: waiting for the first beat's read data
// BEAT1 | second (high) beat of a split access on the bus
// WAIT1 | load: waiting for the second beat's read data
// DONE  | one-cycle completion pulse on resp_valid
module dmem_align_unit
    import dmem_align_unit_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    localparam int BYTES = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [BYTES-1:0]  mem_be,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam int OW = $clog2(BYTES);

    dmem_state_e       state;
    logic              r_we;
    logic              r_unsigned;
    logic              r_split;
    logic [1:0]        r_size;
    logic [OW-1:0]     r_off;
    logic [AWIDTH-1:0] r_base;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] buf_lo;

    logic              idle;
    logic              accept;
    logic              illegal;
    logic              req_split;
    logic [OW-1:0]     req_off;
    logic [AWIDTH-1:0] req_base;

    logic [OW-1:0]       a_off;
    logic [1:0]          a_size;
    logic [DWIDTH-1:0]   a_wdata;
    logic [DWIDTH-1:0]   ld_lo;
    logic [2*BYTES-1:0]  be2;
    logic [2*DWIDTH-1:0] wdata2;
    logic [DWIDTH-1:0]   rdata_ext;
    logic [BYTES-1:0]    be_lo;
    logic [BYTES-1:0]    be_hi;
    logic [DWIDTH-1:0]   wd_lo;
    logic [DWIDTH-1:0]   wd_hi;

    assign idle      = (state == ST_IDLE);
    assign req_ready = idle & ~rst;
    assign accept    = req_valid & req_ready;

    assign req_off   = req_addr[OW-1:0];
    assign req_base  = {req_addr[AWIDTH-1:OW], {OW{1'b0}}};
    assign illegal   = (DWIDTH == 32) && (req_size == DMEM_EXT_DWORD);
    assign req_split = (int'(req_off) + size_bytes(req_size)) > BYTES;

    // Beat0 lanes must be ready on the acceptance edge, so the aligner sees the
    // live request while idle and the captured request afterwards.
    assign a_off   = idle ? req_off   : r_off;
    assign a_size  = idle ? req_size  : r_size;
    assign a_wdata = idle ? req_wdata : r_wdata;

    // The last beat's data is consumed straight off the bus in the same cycle.
    assign ld_lo = (state == ST_WAIT0) ? mem_rdata : buf_lo;

    dmem_lane_align #(
        .DWIDTH(DWIDTH)
    ) u_lane (
        .off        (a_off),
        .size       (a_size),
        .wdata      (a_wdata),
        .rdata_lo   (ld_lo),
        .rdata_hi   (mem_rdata),
        .is_unsigned(r_unsigned),
        .be2        (be2),
        .wdata2     (wdata2),
        .rdata_ext  (rdata_ext)
    );

    assign be_lo = be2[BYTES-1:0];
    assign be_hi = be2[2*BYTES-1:BYTES];
    assign wd_lo = wdata2[DWIDTH-1:0];
    assign wd_hi = wdata2[2*DWIDTH-1:DWIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_split    <= 1'b0;
            r_size     <= '0;
            r_off      <= '0;
            r_base     <= '0;
            r_wdata    <= '0;
            buf_lo     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        r_we       <= req_we;
                        r_unsigned <= req_unsigned;
                        r_split    <= req_split;
                        r_size     <= req_size;
                        r_off      <= req_off;
                        r_base     <= req_base;
                        r_wdata    <= req_wdata;
                        if (illegal) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ST_BEAT0;
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_base;
                            mem_be    <= be_lo;
                            mem_wdata <= req_we ? wd_lo : '0;
                        end
                    end
                end

                ST_BEAT0: begin
                    if (mem_ready) begin
                        if (r_we && r_split) begin
                            state     <= ST_BEAT1;
                            mem_addr  <= r_base + AWIDTH'(BYTES);
                            mem_be    <= be_hi;
                            mem_wdata <= wd_hi;
                        end else begin
                            mem_valid <= 1'b0;
                            mem_be    <= '0;
                            mem_wdata <= '0;
                            if (r_we) begin
                                state      <= ST_DONE;
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b0;
                                resp_rdata <= '0;
                            end else begin
                                state <= ST_WAIT0;
                            end
                        end
                    end
                end

                ST_WAIT0: begin
                    if (mem_rvalid) begin
                        buf_lo <= mem_rdata;
                        if (r_split) begin
                            state     <= ST_BEAT1;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= r_base + AWIDTH'(BYTES);
                            mem_be    <= be_hi;
                            mem_wdata <= '0;
                        end else begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= rdata_ext;
                        end
                    end
                end

                ST_BEAT1: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        if (r_we) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            state <= ST_WAIT1;
                        end
                    end
                end

                ST_WAIT1: begin
                    if (mem_rvalid) begin
                        state      <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= rdata_ext;
                    end
                end

                ST_DONE: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end

                default: begin
                    state     <= ST_IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
